fp_add_norm_pack: RTL

Back end of the IEEE-754 single-precision adder. Consumes the sign-magnitude mantissa result of the big ALU (25-bit {carry, sum}, sign, common aligned exponent, guard/round/sticky bits). Normalizes it iteratively, rounds to nearest-even and packs a 32-bit float. Valid/ready handshake on both sides, so the block can be placed between pipeline stages.

---
 rtl/fp_add_pkg.sv | 32 +++
 rtl/fp_round_rne.sv | 26 ++
 rtl/fp_add_norm_pack.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants, state encoding and result payload for the FP adder back end.
package fp_add_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned SIG_W   = MANT_W + 1;
  localparam int unsigned RND_W   = SIG_W + 1;
  localparam int unsigned EXP_IW  = EXP_W + 2;
  localparam int unsigned DATA_W  = 1 + EXP_W + MANT_W;
  localparam int unsigned GRS_W   = 3;
  localparam int unsigned FLAG_W  = 3;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned BIAS    = 127;

  localparam int unsigned FLAG_OVF = 2;
  localparam int unsigned FLAG_UNF = 1;
  localparam int unsigned FLAG_INX = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a 24-bit significand with guard/round/sticky.
// The inexact output exists only when FP_NORM_FLAGS_EN is defined.
module fp_round_rne
  import fp_add_pkg::*;
(
  input  logic [SIG_W-1:0] i_mant,
  input  logic             i_g,
  input  logic             i_r,
  input  logic             i_s,
`ifdef FP_NORM_FLAGS_EN
  output logic             o_inexact_c,
`endif
  output logic [RND_W-1:0] o_mant_c
);

  logic w_inc;

  // Round up above half, or at exactly half when the kept lsb is odd.
  assign w_inc    = i_g & (i_r | i_s | i_mant[0]);
  assign o_mant_c = {1'b0, i_mant} + RND_W'(w_inc);

`ifdef FP_NORM_FLAGS_EN
  assign o_inexact_c = i_g | i_r | i_s;
`endif

endmodule

// File: rtl/fp_add_norm_pack.sv
// FP adder back end: normalize, round to nearest-even and pack a single-precision result.
// Define FP_NORM_FLAGS_EN to produce overflow/underflow/inexact flags; otherwise flags read 0.
module fp_add_norm_pack
  import fp_add_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W+1:0]   in_mant,
  input  logic [GRS_W-1:0]    in_grs,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic                in_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [FLAG_W-1:0]   out_flags
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [SIG_W-1:0]    r_mant;
  logic                r_g;
  logic                r_r;
  logic                r_s;
  logic [EXP_IW-1:0]   r_exp;
  logic                r_sign;
  logic [DATA_W-1:0]   r_out_data;
  logic [FLAG_W-1:0]   r_out_flags;

  logic                w_accept;
  logic                w_in_zero;
  logic                w_in_direct;
  logic                w_shift;
  logic                w_norm_done;
  logic [RND_W-1:0]    w_rnd_mant;
  logic                w_carry;
  logic                w_hidden;
  logic [EXP_IW-1:0]   w_exp_rnd;
  logic [MANT_W-1:0]   w_frac;
  logic                w_ovf;
  fp32_t               w_res;
  logic [FLAG_W-1:0]   w_flags;

  assign w_accept    = in_valid & r_in_ready;
  assign w_in_zero   = (in_mant == '0) && (in_grs == '0);
  // Already normalized, carry-out or already at the minimum exponent: no left shifts needed.
  assign w_in_direct = in_mant[SIG_W] | in_mant[SIG_W-1] | (in_exp == EXP_W'(1));

  assign w_shift     = !r_mant[SIG_W-1] && (r_exp > EXP_IW'(1));
  assign w_norm_done = !w_shift || r_mant[SIG_W-2] || (r_exp == EXP_IW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_zero)        w_state_nxt = OUT;
          else if (w_in_direct) w_state_nxt = ROUND;
          else                  w_state_nxt = NORM;
        end
      end
      NORM:    if (w_norm_done) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == OUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mant      <= '0;
      r_g         <= 1'b0;
      r_r         <= 1'b0;
      r_s         <= 1'b0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign <= in_sign;
            if (in_mant[SIG_W]) begin
              r_mant <= in_mant[SIG_W:1];
              r_g    <= in_mant[0];
              r_r    <= in_grs[2];
              r_s    <= in_grs[1] | in_grs[0];
              r_exp  <= EXP_IW'(in_exp) + EXP_IW'(1);
            end else begin
              r_mant <= in_mant[SIG_W-1:0];
              r_g    <= in_grs[2];
              r_r    <= in_grs[1];
              r_s    <= in_grs[0];
              r_exp  <= EXP_IW'(in_exp);
            end
            if (w_in_zero) begin
              r_out_data  <= '0;
              r_out_flags <= '0;
            end
          end
        end
        NORM: begin
          if (w_shift) begin
            r_mant <= {r_mant[SIG_W-2:0], r_g};
            r_g    <= r_r;
            r_r    <= 1'b0;
            r_exp  <= r_exp - EXP_IW'(1);
          end
        end
        ROUND: begin
          r_out_data  <= w_res;
          r_out_flags <= w_flags;
        end
        default: ;
      endcase
    end
  end

`ifdef FP_NORM_FLAGS_EN
  logic w_inexact;
`endif

  fp_round_rne u_round (
    .i_mant      (r_mant),
    .i_g         (r_g),
    .i_r         (r_r),
    .i_s         (r_s),
`ifdef FP_NORM_FLAGS_EN
    .o_inexact_c (w_inexact),
`endif
    .o_mant_c    (w_rnd_mant)
  );

  assign w_carry   = w_rnd_mant[SIG_W];
  assign w_hidden  = w_carry | w_rnd_mant[SIG_W-1];
  assign w_exp_rnd = r_exp + EXP_IW'(w_carry);
  assign w_frac    = w_carry ? w_rnd_mant[SIG_W-1:1] : w_rnd_mant[MANT_W-1:0];
  assign w_ovf     = (w_exp_rnd >= EXP_IW'(EXP_MAX));

  // A tiny result without the hidden bit packs with exponent field 0.
  always_comb begin
    w_res      = '0;
    w_res.sign = r_sign;
    if (w_ovf) begin
      w_res.expo = '1;
      w_res.frac = '0;
    end else begin
      w_res.expo = w_hidden ? w_exp_rnd[EXP_W-1:0] : '0;
      w_res.frac = w_frac;
    end
  end

`ifdef FP_NORM_FLAGS_EN
  always_comb begin
    w_flags           = '0;
    w_flags[FLAG_OVF] = w_ovf;
    w_flags[FLAG_UNF] = !r_mant[SIG_W-1] & w_inexact;
    w_flags[FLAG_INX] = w_inexact | w_ovf;
  end
`else
  assign w_flags = '0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

endmodule
